stream_scoreboard: RTL and testbench
====================================

Name: stream_scoreboard

Overview:
- Synthesizable end-of-stream checker; the receive-side counterpart of the stimulus driver.
- The driver pushes each value it writes into the DUT as an expected word.
- The block pops one expected word per observed DUT output word, compares them, and keeps pass/fail statistics.
- Sits beside the DUT in self-checking benches and on-chip loopback tests.

Parameters:
- DATA_W, 8, width of expected/observed data
- DEPTH, 8, expected-word FIFO entries; power of two, >= 2
- CNT_W, 16, width of match/mismatch counters
- TIMEOUT, 64, max idle cycles in DRAIN before declaring timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse: clear statistics, enter RUN
- stop  in  1  pulse: stop accepting expected words, enter DRAIN
- exp_valid  in  1  expected word present this cycle
- exp_data  in  DATA_W  expected word
- exp_ready  out  1  FIFO can accept (state RUN and not full, or full with a pop this cycle)
- obs_valid  in  1  DUT output word present this cycle
- obs_data  in  DATA_W  DUT output word
- state  out  2  current sb_state_e
- match_count  out  CNT_W  compares that matched
- mismatch_count  out  CNT_W  compares that differed
- mismatch  out  1  one-cycle pulse, registered, on each failed compare
- first_exp  out  DATA_W  expected value of first mismatch
- first_obs  out  DATA_W  observed value of first mismatch
- underflow  out  1  sticky: obs_valid with nothing to compare against
- overflow  out  1  sticky: exp_valid in RUN while full and no pop
- timeout  out  1  sticky: DRAIN expired with FIFO non-empty
- done  out  1  high in DONE
- pass  out  1  done and no mismatch, underflow, overflow or timeout

Behaviour:
- Reset: state=IDLE; FIFO empty; all counters, flags, first_exp/first_obs = 0; exp_ready=0; done=pass=0.
- IDLE:
  - exp_valid and obs_valid are ignored.
  - start -> RUN (next cycle).
  - stop is ignored.
- RUN:
  - Push when exp_valid and exp_ready.
  - On obs_valid, pop the FIFO head and compare with obs_data; the result is registered, so counters and the mismatch pulse update 1 cycle after obs_valid.
  - Bypass: if the FIFO is empty and exp_valid and obs_valid are both high in the same cycle, compare obs_data directly against exp_data. Nothing is pushed; this is not an underflow.
  - Full with a simultaneous pop: the push is accepted and occupancy is unchanged.
  - Full without a pop and exp_valid: the word is dropped and overflow is set.
  - FIFO empty and obs_valid without bypass: underflow is set, no compare, counters unchanged.
  - stop -> DRAIN. If start and stop arrive in the same cycle, stop wins. start in RUN is ignored.
- DRAIN:
  - exp_ready=0; exp_valid is ignored and sets no flags.
  - obs_valid pops and compares as in RUN.
  - An idle counter resets on every obs_valid and increments otherwise.
  - FIFO empty -> DONE.
  - Idle counter reaches TIMEOUT-1 with the FIFO non-empty -> DONE with timeout set.
- DONE:
  - done=1; pass is combinational from the flags.
  - All inputs are ignored except start, which clears counters, flags and the FIFO and moves to RUN.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- first_exp/first_obs capture only on the first mismatch after start or reset.
- FIFO pointers are log2(DEPTH)+1 bits wide, with wrap detected by the MSB.
- Reset mid-operation returns to the reset state in the next cycle regardless of state.

Decomposition:
- Package sb_pkg holds:
  - typedef enum logic [1:0] sb_state_e {SB_IDLE, SB_RUN, SB_DRAIN, SB_DONE};
  - localparam helpers for pointer width.
- Sub-module sb_fifo: synchronous FIFO with push/pop, full/empty, head output (first-word fall-through), parameterised DATA_W/DEPTH.
- The scoreboard holds the FSM, compare stage, counters and flags.

Test Plan:
- Reset, start, push 0xFF then 0xAA, observe 0xFF then 0xAA two cycles later, stop -> match_count=2, mismatch_count=0, DONE with pass=1.
- Push 0xAA, observe 0x55 -> mismatch pulse one cycle later, mismatch_count=1, first_exp=0xAA, first_obs=0x55, pass=0 at DONE.
- Bypass: FIFO empty, exp_valid=1/exp_data=0x3C and obs_valid=1/obs_data=0x3C in the same cycle -> match_count=1, FIFO stays empty, underflow=0.
- Push 9 words with DEPTH=8 and no observations -> 9th dropped, overflow=1, exp_ready=0. Then push+pop together while full -> occupancy stays 8, no new overflow.
- obs_valid in RUN with an empty FIFO -> underflow=1, counters unchanged. Then push 3 words, stop, observe 1 word and wait TIMEOUT cycles -> DONE, timeout=1, pass=0.
- Assert rst during DRAIN with 4 words queued -> next cycle state=IDLE, all counters and flags 0. Then start -> RUN with an empty FIFO.

Source files
------------

// File: rtl/sb_pkg.sv
// sb_pkg: shared types and helpers for the stream scoreboard.
//   sb_state_e : scoreboard FSM states (IDLE, RUN, DRAIN, DONE)
//   sb_ptr_w() : FIFO pointer width; one bit more than the address so that
//                full and empty can be told apart by the MSB.
package sb_pkg;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_RUN   = 2'd1,
    SB_DRAIN = 2'd2,
    SB_DONE  = 2'd3
  } sb_state_e;

  localparam int SB_MIN_DEPTH = 2;

  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: synchronous first-word-fall-through FIFO for expected words.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : synchronous flush (pointers back to zero)
//   i_push    : write i_data (honoured when not full, or full with a pop)
//   i_data    : word to write
//   i_pop     : drop the head word (honoured when not empty)
//   o_head    : current head word, valid whenever o_empty is low
//   o_full    : DEPTH words stored
//   o_empty   : no words stored
module sb_fifo
  import sb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = sb_ptr_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Same address with differing MSBs means the writer has lapped the reader.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_head = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/stream_scoreboard.sv
// stream_scoreboard: end-of-stream checker. Expected words are queued in a
// FIFO; every observed word pops one and is compared, with saturating
// match/mismatch statistics and sticky error flags.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start / stop      : begin a run (clears stats) / stop queueing and drain
//   exp_valid/data    : expected word from the stimulus side
//   exp_ready         : expected word can be accepted this cycle
//   obs_valid/data    : observed DUT output word
//   state             : current FSM state
//   match_count       : compares that matched (saturating)
//   mismatch_count    : compares that differed (saturating)
//   mismatch          : one-cycle pulse per failed compare
//   first_exp/obs     : operands of the first mismatch since start/reset
//   underflow         : sticky, observed word with nothing to compare against
//   overflow          : sticky, expected word dropped because FIFO was full
//   timeout           : sticky, drain gave up with words still queued
//   done / pass       : run finished / finished cleanly
module stream_scoreboard
  import sb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              exp_valid,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  input  logic              obs_valid,
  input  logic [DATA_W-1:0] obs_data,
  output sb_state_e         state,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic              mismatch,
  output logic [DATA_W-1:0] first_exp,
  output logic [DATA_W-1:0] first_obs,
  output logic              underflow,
  output logic              overflow,
  output logic              timeout,
  output logic              done,
  output logic              pass
);

  localparam int IDLE_W = $clog2(TIMEOUT) + 1;

  sb_state_e         r_state;
  logic [CNT_W-1:0]  r_match_count;
  logic [CNT_W-1:0]  r_mismatch_count;
  logic              r_mismatch;
  logic [DATA_W-1:0] r_first_exp;
  logic [DATA_W-1:0] r_first_obs;
  logic              r_have_first;
  logic              r_underflow;
  logic              r_overflow;
  logic              r_timeout;
  logic [IDLE_W-1:0] r_idle;

  logic              w_run;
  logic              w_active;
  logic              w_clear;
  logic              w_bypass;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              w_cmp_valid;
  logic [DATA_W-1:0] w_cmp_exp;
  logic              w_cmp_ok;
  logic              w_set_ovf;
  logic              w_set_udf;

  assign w_run    = (r_state == SB_RUN);
  assign w_active = (r_state == SB_RUN) || (r_state == SB_DRAIN);
  // start only has effect from IDLE or DONE; in RUN it is ignored.
  assign w_clear  = start && ((r_state == SB_IDLE) || (r_state == SB_DONE));

  // Empty FIFO with both sides valid: compare directly, never store the word.
  assign w_bypass  = w_run && w_empty && exp_valid && obs_valid;
  assign w_pop     = w_active && obs_valid && !w_empty;
  assign exp_ready = w_run && (!w_full || w_pop);
  assign w_push    = w_run && exp_valid && exp_ready && !w_bypass;
  assign w_set_ovf = w_run && exp_valid && w_full && !w_pop;
  assign w_set_udf = w_active && obs_valid && w_empty && !w_bypass;

  assign w_cmp_valid = w_pop || w_bypass;
  assign w_cmp_exp   = w_bypass ? exp_data : w_head;
  assign w_cmp_ok    = (w_cmp_exp == obs_data);

  sb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clear),
    .i_push  (w_push),
    .i_data  (exp_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= SB_IDLE;
      r_match_count    <= '0;
      r_mismatch_count <= '0;
      r_mismatch       <= 1'b0;
      r_first_exp      <= '0;
      r_first_obs      <= '0;
      r_have_first     <= 1'b0;
      r_underflow      <= 1'b0;
      r_overflow       <= 1'b0;
      r_timeout        <= 1'b0;
      r_idle           <= '0;
    end else begin
      r_mismatch <= 1'b0;

      // Statistics: a clear and a compare never coincide because compares
      // only happen in RUN/DRAIN while clears only happen in IDLE/DONE.
      if (w_clear) begin
        r_match_count    <= '0;
        r_mismatch_count <= '0;
        r_first_exp      <= '0;
        r_first_obs      <= '0;
        r_have_first     <= 1'b0;
        r_underflow      <= 1'b0;
        r_overflow       <= 1'b0;
        r_timeout        <= 1'b0;
      end else begin
        if (w_cmp_valid) begin
          if (w_cmp_ok) begin
            if (r_match_count != '1) r_match_count <= r_match_count + CNT_W'(1);
          end else begin
            r_mismatch <= 1'b1;
            if (r_mismatch_count != '1) r_mismatch_count <= r_mismatch_count + CNT_W'(1);
            if (!r_have_first) begin
              r_first_exp  <= w_cmp_exp;
              r_first_obs  <= obs_data;
              r_have_first <= 1'b1;
            end
          end
        end
        if (w_set_udf) r_underflow <= 1'b1;
        if (w_set_ovf) r_overflow  <= 1'b1;
      end

      case (r_state)
        SB_IDLE: begin
          if (start) r_state <= SB_RUN;
        end
        SB_RUN: begin
          if (stop) begin
            r_state <= SB_DRAIN;
            r_idle  <= '0;
          end
        end
        SB_DRAIN: begin
          r_idle <= obs_valid ? '0 : r_idle + IDLE_W'(1);
          if (w_empty) begin
            r_state <= SB_DONE;
          end else if (r_idle == IDLE_W'(TIMEOUT - 1)) begin
            r_state   <= SB_DONE;
            r_timeout <= 1'b1;
          end
        end
        SB_DONE: begin
          if (start) r_state <= SB_RUN;
        end
        default: r_state <= SB_IDLE;
      endcase
    end
  end

  assign state          = r_state;
  assign match_count    = r_match_count;
  assign mismatch_count = r_mismatch_count;
  assign mismatch       = r_mismatch;
  assign first_exp      = r_first_exp;
  assign first_obs      = r_first_obs;
  assign underflow      = r_underflow;
  assign overflow       = r_overflow;
  assign timeout        = r_timeout;
  assign done           = (r_state == SB_DONE);
  assign pass           = done && (r_mismatch_count == '0) &&
                          !r_underflow && !r_overflow && !r_timeout;

endmodule

// File: tb/tb_stream_scoreboard.sv
// tb_stream_scoreboard: directed vector table plus hand-written sequences for
// overflow, underflow/timeout and reset-during-drain.
module tb_stream_scoreboard;
  import sb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, exp_valid, obs_valid;
  logic [7:0]  exp_data, obs_data;
  logic        exp_ready;
  sb_state_e   state;
  logic [15:0] match_count, mismatch_count;
  logic        mismatch, underflow, overflow, timeout, done, pass;
  logic [7:0]  first_exp, first_obs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_scoreboard #(.DATA_W(8), .DEPTH(8), .CNT_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .obs_valid(obs_valid), .obs_data(obs_data), .state(state),
    .match_count(match_count), .mismatch_count(mismatch_count),
    .mismatch(mismatch), .first_exp(first_exp), .first_obs(first_obs),
    .underflow(underflow), .overflow(overflow), .timeout(timeout),
    .done(done), .pass(pass)
  );

  typedef struct {
    logic       st, sp, ev;
    logic [7:0] ed;
    logic       ov;
    logic [7:0] od;
    logic       rdy;
    logic [1:0] s;
    logic [15:0] mc, mmc;
    logic       mm, uf, of, dn, ps;
    logic [7:0] fe, fo;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(logic st, logic sp, logic ev, logic [7:0] ed,
                              logic ov, logic [7:0] od, logic rdy, logic [1:0] s,
                              logic [15:0] mc, logic [15:0] mmc, logic mm, logic uf,
                              logic of, logic dn, logic ps, logic [7:0] fe, logic [7:0] fo);
    vec_t v;
    v.st = st; v.sp = sp; v.ev = ev; v.ed = ed; v.ov = ov; v.od = od;
    v.rdy = rdy; v.s = s; v.mc = mc; v.mmc = mmc; v.mm = mm; v.uf = uf;
    v.of = of; v.dn = dn; v.ps = ps; v.fe = fe; v.fo = fo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic ev, input logic [7:0] ed,
                       input logic ov, input logic [7:0] od);
    start = st; stop = sp; exp_valid = ev; exp_data = ed; obs_valid = ov; obs_data = od;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 0, 8'h00);
    repeat (3) cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_state", state, SB_IDLE);
    chk("rst_match", match_count, 0);
    chk("rst_mismatch_cnt", mismatch_count, 0);
    chk("rst_flags", {mismatch, underflow, overflow, timeout}, 0);
    chk("rst_first", {first_exp, first_obs}, 0);
    chk("rst_ready", exp_ready, 0);
    chk("rst_done_pass", {done, pass}, 0);

    //                st sp ev ed     ov od     rdy s         mc mmc mm uf of dn ps fe     fo
    vecs[0]  = mk(0, 1, 1, 8'h05, 1, 8'h05, 0, SB_IDLE,  0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[1]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, SB_RUN,   0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[2]  = mk(0, 0, 1, 8'hFF, 0, 8'h00, 1, SB_RUN,   0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[3]  = mk(0, 0, 1, 8'hAA, 0, 8'h00, 1, SB_RUN,   0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[4]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, SB_RUN,   0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[5]  = mk(0, 0, 0, 8'h00, 1, 8'hFF, 1, SB_RUN,   1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[6]  = mk(0, 0, 0, 8'h00, 1, 8'hAA, 1, SB_RUN,   2, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[7]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, SB_DRAIN, 2, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[8]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, SB_DONE,  2, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
    vecs[9]  = mk(0, 1, 1, 8'h12, 1, 8'h34, 0, SB_DONE,  2, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
    vecs[10] = mk(1, 0, 1, 8'hAA, 0, 8'h00, 0, SB_RUN,   0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[11] = mk(0, 0, 1, 8'hAA, 0, 8'h00, 1, SB_RUN,   0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[12] = mk(0, 0, 0, 8'h00, 1, 8'h55, 1, SB_RUN,   0, 1, 1, 0, 0, 0, 0, 8'hAA, 8'h55);
    vecs[13] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, SB_RUN,   0, 1, 0, 0, 0, 0, 0, 8'hAA, 8'h55);
    vecs[14] = mk(0, 0, 1, 8'h3C, 1, 8'h3C, 1, SB_RUN,   1, 1, 0, 0, 0, 0, 0, 8'hAA, 8'h55);
    vecs[15] = mk(0, 0, 1, 8'h01, 1, 8'h02, 1, SB_RUN,   1, 2, 1, 0, 0, 0, 0, 8'hAA, 8'h55);
    vecs[16] = mk(0, 1, 0, 8'h00, 0, 8'h00, 1, SB_DRAIN, 1, 2, 0, 0, 0, 0, 0, 8'hAA, 8'h55);
    vecs[17] = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, SB_DONE,  1, 2, 0, 0, 0, 1, 0, 8'hAA, 8'h55);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].ev, vecs[i].ed, vecs[i].ov, vecs[i].od);
      #1;
      chk($sformatf("v%0d_exp_ready", i), exp_ready, vecs[i].rdy);
      cyc();
      chk($sformatf("v%0d_state", i), state, vecs[i].s);
      chk($sformatf("v%0d_match", i), match_count, vecs[i].mc);
      chk($sformatf("v%0d_mismatch_cnt", i), mismatch_count, vecs[i].mmc);
      chk($sformatf("v%0d_mismatch", i), mismatch, vecs[i].mm);
      chk($sformatf("v%0d_underflow", i), underflow, vecs[i].uf);
      chk($sformatf("v%0d_overflow", i), overflow, vecs[i].of);
      chk($sformatf("v%0d_done", i), done, vecs[i].dn);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].ps);
      chk($sformatf("v%0d_first", i), {first_exp, first_obs}, {vecs[i].fe, vecs[i].fo});
      $display("vector %0d: state=%0d match=%0d mismatch=%0d done=%0b pass=%0b",
               i, state, match_count, mismatch_count, done, pass);
    end

    // Overflow: fill, drop a 9th word, then push+pop while full.
    drive(1, 0, 0, 8'h00, 0, 8'h00); cyc();
    chk("ovf_start_state", state, SB_RUN);
    chk("ovf_start_clear", {match_count, mismatch_count}, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 8'h10 + 8'(i), 0, 8'h00);
      #1;
      chk($sformatf("ovf_fill%0d_ready", i), exp_ready, 1);
      cyc();
    end
    drive(0, 0, 1, 8'h99, 0, 8'h00);
    #1;
    chk("ovf_full_ready", exp_ready, 0);
    cyc();
    chk("ovf_flag", overflow, 1);
    drive(0, 0, 1, 8'h20, 1, 8'h10);
    #1;
    chk("ovf_pushpop_ready", exp_ready, 1);
    cyc();
    chk("ovf_pushpop_match", match_count, 1);
    drive(0, 0, 0, 8'h00, 0, 8'h00);
    #1;
    chk("ovf_still_full", exp_ready, 0);
    cyc();
    drive(0, 1, 0, 8'h00, 0, 8'h00); cyc();
    chk("ovf_drain_state", state, SB_DRAIN);
    for (int i = 1; i < 8; i++) begin
      drive(0, 0, 0, 8'h00, 1, 8'h10 + 8'(i)); cyc();
    end
    drive(0, 0, 0, 8'h00, 1, 8'h20); cyc();
    chk("ovf_drain_match", match_count, 9);
    chk("ovf_drain_mismatch", mismatch_count, 0);
    drive(0, 0, 0, 8'h00, 0, 8'h00); cyc();
    chk("ovf_done", {done, pass, overflow, underflow}, 4'b1010);
    $display("overflow seq: match=%0d overflow=%0b pass=%0b", match_count, overflow, pass);

    // Underflow, start ignored in RUN, then drain timeout.
    drive(1, 0, 0, 8'h00, 0, 8'h00); cyc();
    chk("udf_start_clear", {overflow, underflow, timeout}, 0);
    drive(0, 0, 0, 8'h00, 1, 8'h77); cyc();
    chk("udf_flag", underflow, 1);
    chk("udf_counts", {match_count, mismatch_count, 15'd0, mismatch}, 0);
    drive(1, 0, 1, 8'h01, 0, 8'h00); cyc();
    chk("udf_start_in_run", {state, underflow}, {SB_RUN, 1'b1});
    drive(0, 0, 1, 8'h02, 0, 8'h00); cyc();
    drive(0, 0, 1, 8'h03, 0, 8'h00); cyc();
    drive(0, 1, 0, 8'h00, 0, 8'h00); cyc();
    chk("tmo_drain_state", state, SB_DRAIN);
    drive(0, 0, 1, 8'h09, 1, 8'h01); cyc();
    chk("tmo_one_match", match_count, 1);
    drive(0, 0, 0, 8'h00, 0, 8'h00);
    n = 0;
    while (state != SB_DONE && n < 200) begin
      cyc();
      n++;
    end
    chk("tmo_cycles", n, 64);
    chk("tmo_flags", {done, timeout, pass}, 3'b110);
    $display("timeout seq: idle cycles=%0d timeout=%0b pass=%0b", n, timeout, pass);

    // Reset during DRAIN with four words queued.
    drive(1, 0, 0, 8'h00, 0, 8'h00); cyc();
    chk("rdr_start_clear", {timeout, underflow}, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 8'hA0 + 8'(i), 0, 8'h00); cyc();
    end
    drive(0, 0, 0, 8'h00, 1, 8'h00); cyc();
    chk("rdr_mismatch", {mismatch, mismatch_count}, {1'b1, 16'd1});
    chk("rdr_first", {first_exp, first_obs}, {8'hA0, 8'h00});
    drive(1, 1, 0, 8'h00, 0, 8'h00); cyc();
    chk("rdr_stop_wins", state, SB_DRAIN);
    chk("rdr_no_clear", mismatch_count, 1);
    drive(0, 0, 0, 8'h00, 0, 8'h00);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rdr_state", state, SB_IDLE);
    chk("rdr_counts", {match_count, mismatch_count}, 0);
    chk("rdr_flags", {mismatch, underflow, overflow, timeout, done, pass}, 0);
    chk("rdr_first_clr", {first_exp, first_obs}, 0);
    chk("rdr_ready", exp_ready, 0);
    drive(1, 0, 0, 8'h00, 0, 8'h00); cyc();
    chk("rdr_restart", state, SB_RUN);
    drive(0, 1, 0, 8'h00, 0, 8'h00); cyc();
    drive(0, 0, 0, 8'h00, 0, 8'h00); cyc();
    chk("rdr_empty_done", {state, done, pass}, {SB_DONE, 1'b1, 1'b1});
    $display("reset seq: state=%0d done=%0b pass=%0b", state, done, pass);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
